// File: rtl/source_out_1bit_sched_pkg.sv
// Shared definitions for the 1-bit source-lane scheduler: FSM state encoding
// and a ceiling-log2 helper that never returns less than one bit.
package source_out_1bit_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin pick: first set request strictly after rr_ptr,
// wrapping modulo NREQ. rr_ptr itself is the lowest-priority candidate.
module rr_arbiter_pick
  import source_out_1bit_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic            grant_valid,
  output logic [IDW-1:0]  grant_id
);

  // Walk candidates farthest-first so the nearest set request overwrites last.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_id    = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/source_out_1bit_sched.sv
// Round-robin scheduler sharing one serial output lane among NREQ requesters:
// grant, capture a word, shift it out MSB-first, then hold an idle gap.
module source_out_1bit_sched
  import source_out_1bit_sched_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int WORD_W = 16,
  parameter int GAP    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ*WORD_W-1:0]        word_in,
  output logic [NREQ-1:0]               ack,
  input  logic                          out_en,
  output logic                          ser_en,
  output logic                          ser_data,
  output logic                          busy,
  output logic [clog2_min1(NREQ)-1:0]   cur_id
);

  localparam int IDW      = clog2_min1(NREQ);
  localparam int BCW      = clog2_min1(WORD_W);
  localparam int GCW      = clog2_min1(GAP + 1);
  localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

  state_t             state;
  logic [IDW-1:0]     rr_ptr;
  logic [BCW-1:0]     bit_cnt;
  logic [GCW-1:0]     gap_cnt;
  logic [WORD_W-1:0]  shreg;
  logic               grant_valid;
  logic [IDW-1:0]     grant_id;

  rr_arbiter_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req         (req),
    .rr_ptr      (rr_ptr),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Reset also aborts an in-flight frame: remaining bits are dropped, no ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= IDW'(NREQ - 1);
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      shreg    <= '0;
      ack      <= '0;
      ser_en   <= 1'b0;
      ser_data <= 1'b0;
      busy     <= 1'b0;
      cur_id   <= '0;
    end else begin
      ack <= '0;
      case (state)
        ST_IDLE: begin
          ser_en <= 1'b0;
          if (grant_valid) begin
            shreg   <= word_in[int'(grant_id)*WORD_W +: WORD_W];
            ack     <= NREQ'(1) << grant_id;
            cur_id  <= grant_id;
            rr_ptr  <= grant_id;
            bit_cnt <= '0;
            state   <= ST_SHIFT;
            busy    <= 1'b1;
          end
        end
        ST_SHIFT: begin
          // A stalled lane keeps the current bit and count; only ser_en drops.
          if (out_en) begin
            ser_en   <= 1'b1;
            ser_data <= shreg[WORD_W-1];
            shreg    <= {shreg[WORD_W-2:0], 1'b0};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == BCW'(WORD_W - 1)) begin
              if (GAP == 0) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end else begin
                state   <= ST_GAP;
                gap_cnt <= '0;
              end
            end
          end else begin
            ser_en <= 1'b0;
          end
        end
        ST_GAP: begin
          ser_en  <= 1'b0;
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GCW'(GAP_LAST)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          ser_en <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_source_out_1bit_sched.sv
// Self-checking bench: frame-level reference model predicts grants, serial bits,
// busy and cur_id each cycle; a second GAP=0 instance checks back-to-back framing.
module tb_source_out_1bit_sched;

  localparam int NREQ   = 4;
  localparam int WORD_W = 16;
  localparam int GAP    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [63:0] word_in;
  logic [3:0]  ack;
  logic        out_en, ser_en, ser_data, busy;
  logic [1:0]  cur_id;

  logic [3:0]  req2;
  logic [63:0] word_in2;
  logic [3:0]  ack2;
  logic        out_en2, ser_en2, ser_data2, busy2;
  logic [1:0]  cur_id2;

  always #5 clk = ~clk;

  source_out_1bit_sched #(.NREQ(NREQ), .WORD_W(WORD_W), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .word_in(word_in), .ack(ack),
    .out_en(out_en), .ser_en(ser_en), .ser_data(ser_data), .busy(busy), .cur_id(cur_id)
  );

  source_out_1bit_sched #(.NREQ(NREQ), .WORD_W(WORD_W), .GAP(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .word_in(word_in2), .ack(ack2),
    .out_en(out_en2), .ser_en(ser_en2), .ser_data(ser_data2), .busy(busy2), .cur_id(cur_id2)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state (frame level)
  int          cyc = 0;
  bit          m_open;
  logic [15:0] m_word;
  int          m_left;
  int          m_ready;
  int          m_rr;
  int          m_cur;
  int          ack_log[$];
  int          ack_cyc[$];
  int          bits_seen;
  logic [15:0] rx_word;
  bit          zero_seen;

  // GAP=0 instance monitor
  bit          t6 = 0;
  int          m2_next = 0;
  logic [15:0] m2_word = '0;
  int          hi_run = 0, lo_run = 0, frames2 = 0;
  logic [15:0] rx2 = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_open  = 0;
    m_ready = 0;
    m_rr    = NREQ - 1;
    m_cur   = 0;
  endtask

  task automatic tick();
    logic [3:0] e_ack;
    logic       e_en, e_bit;
    int         g;
    @(posedge clk);
    #1;
    cyc++;
    e_ack = '0; e_en = 1'b0; e_bit = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (m_open) begin
      if (out_en) begin
        e_en  = 1'b1;
        e_bit = m_word[m_left-1];
        m_left--;
        if (m_left == 0) begin
          m_open  = 0;
          m_ready = cyc + GAP + 1;
        end
      end
    end else if (cyc >= m_ready && req != 0) begin
      g = m_rr;
      for (int k = 0; k < NREQ; k++) begin
        g = (g + 1) % NREQ;
        if (req[g]) break;
      end
      e_ack  = 4'(1 << g);
      m_open = 1;
      m_word = word_in[g*WORD_W +: WORD_W];
      m_left = WORD_W;
      m_rr   = g;
      m_cur  = g;
      ack_log.push_back(g);
      ack_cyc.push_back(cyc);
    end
    chk("ack", ack, e_ack);
    chk("ser_en", ser_en, e_en);
    if (e_en) chk("ser_data", ser_data, e_bit);
    chk("busy", busy, (m_open || cyc < m_ready - 1));
    chk("cur_id", cur_id, m_cur);
    if (ser_en) begin
      rx_word = {rx_word[14:0], ser_data};
      bits_seen++;
      if (!ser_data) zero_seen = 1;
    end
    if (t6) begin
      if (ser_en2) begin
        if (lo_run > 0 && frames2 > 0) chk("gap0_idle_len", lo_run, 1);
        lo_run = 0;
        hi_run++;
        rx2 = {rx2[14:0], ser_data2};
      end else begin
        if (hi_run > 0) begin
          chk("gap0_frame_len", hi_run, 16);
          chk("gap0_word", rx2, m2_word);
          frames2++;
        end
        hi_run = 0;
        lo_run++;
      end
      if (ack2 != 0) begin
        chk("gap0_ack", ack2, 4'(1 << m2_next));
        m2_word = word_in2[m2_next*WORD_W +: WORD_W];
        m2_next ^= 1;
      end
    end
  endtask

  task automatic wait_ack(input string tag, input int budget);
    bit got;
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (ack != 0) got = 1;
    end
    if (!got) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_bits(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && bits_seen < n; i++) tick();
    if (bits_seen < n) chk({tag, "_timeout"}, bits_seen, n);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] nreq;
    int         d;
    model_reset();
    rst_n    = 1'b0;
    req      = 4'hF;
    out_en   = 1'b1;
    word_in  = {$urandom, $urandom};
    req2     = '0;
    out_en2  = 1'b1;
    word_in2 = 64'h0000_0000_3C96_B00B;

    // 1: reset held with all requests pending, then requester 0 wins first
    repeat (5) tick();
    chk("rst_ack", ack, 0);
    chk("rst_ser_en", ser_en, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    chk("first_grant", ack, 4'b0001);
    req = '0;
    repeat (25) tick();

    // 2: single frame from requester 2
    req = 4'b0100;
    word_in[47:32] = 16'hA5C3;
    wait_ack("single", 5);
    chk("single_cur_id", cur_id, 2);
    req = '0;
    bits_seen = 0;
    repeat (16) tick();
    chk("single_bits", bits_seen, 16);
    chk("single_word", rx_word, 16'hA5C3);
    repeat (2) tick();
    chk("single_busy_drop", busy, 0);
    repeat (3) tick();

    // 3: round robin with all requests held, 8 frames
    reset_dut();
    ack_log.delete();
    ack_cyc.delete();
    req = 4'hF;
    for (int i = 0; i < 8 * 19 + 40 && ack_log.size() < 8; i++) begin
      tick();
      for (int r = 0; r < NREQ; r++)
        if (ack[r]) word_in[r*WORD_W +: WORD_W] = 16'($urandom);
    end
    req = '0;
    chk("rr_frames", ack_log.size(), 8);
    for (int i = 0; i < ack_log.size(); i++) chk("rr_order", ack_log[i], i % 4);
    for (int i = 1; i < ack_cyc.size(); i++) begin
      d = ack_cyc[i] - ack_cyc[i-1];
      chk("rr_period", d, 19);
    end
    repeat (25) tick();

    // 4: stall after bit 5 of an all-ones word
    req = 4'b0001;
    word_in[15:0] = 16'hFFFF;
    wait_ack("stall", 5);
    req = '0;
    bits_seen = 0;
    zero_seen = 0;
    wait_bits("stall_pre", 6, 20);
    out_en = 1'b0;
    repeat (3) tick();
    chk("stall_held_bits", bits_seen, 6);
    out_en = 1'b1;
    wait_bits("stall_post", 16, 30);
    repeat (5) tick();
    chk("stall_total_bits", bits_seen, 16);
    chk("stall_no_zero", zero_seen, 0);

    // 5: asynchronous abort after bit 7
    req = 4'b0010;
    word_in[31:16] = 16'($urandom) | 16'h0001;
    wait_ack("abort", 5);
    req = '0;
    bits_seen = 0;
    wait_bits("abort_pre", 8, 20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_ser_en", ser_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ack", ack, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    bits_seen = 0;
    repeat (25) tick();
    chk("abort_residual", bits_seen, 0);
    chk("abort_idle", busy, 0);

    // Randomized traffic with stalls; words only change when not pending or just acked
    for (int i = 0; i < 400; i++) begin
      tick();
      out_en = ($urandom_range(0, 3) != 0);
      nreq = 4'($urandom);
      for (int r = 0; r < NREQ; r++)
        if (!req[r] || ack[r]) word_in[r*WORD_W +: WORD_W] = 16'($urandom);
      req = nreq;
    end
    req = '0;
    out_en = 1'b1;
    repeat (25) tick();

    // 6: GAP=0 instance, two requesters held
    t6 = 1;
    req2 = 4'b0011;
    repeat (80) tick();
    chk("gap0_frames", (frames2 >= 4), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
